cpu_clk_ctrl: RTL and testbench

Upstream run-control stage for the MIPS_R2000 core. It turns the board clock into a one-cycle CPU tick enable (CLK_EN) according to a run mode: halt, run fast, run slow, or single-step on a debounced button. It counts issued ticks and stops the core at a programmable cycle limit. It replaces the bench-side cycle limiter and the free-running divider; the core's state registers advance only on CLK when CLK_EN=1.

---
 rtl/cpu_clk_ctrl_pkg.sv | 29 ++
 rtl/cpu_clk_ctrl_btn_debounce.sv | 55 +++++
 rtl/cpu_clk_ctrl.sv | 158 +++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared encodings for the CPU run-control block: run modes, FSM states, defaults.
package cpu_ctrl_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_FAST = 2'b01,
        MODE_SLOW = 2'b10,
        MODE_STEP = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        S_HALT  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_LIMIT = 3'd3,
        S_BRK   = 3'd4
    } state_e;

    function automatic state_e mode_to_state(input logic [1:0] mode);
        case (mode_e'(mode))
            MODE_HALT: return S_HALT;
            MODE_STEP: return S_STEP;
            default:   return S_RUN;
        endcase
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Step-button conditioning: 2-flop synchroniser, stability counter and a one-cycle
// pulse on each accepted rising edge of the debounced level.
module btn_debounce
    import cpu_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic rise_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synced input disagrees with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_TC) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU run control: turns the board clock into a one-cycle tick enable per run mode,
// counts ticks and stops at a cycle limit. Optional breakpoint: CLK_CTRL_BREAK_EN.
//
// state   | meaning
// S_HALT  | MODE=00, no ticks, HALTED=1
// S_RUN   | MODE=01/10, divider produces a tick every DIV cycles
// S_STEP  | MODE=11, one tick per debounced button press
// S_LIMIT | tick limit reached, waits for CLR_CNT or RST
// S_BRK   | PC matched breakpoint, halted until MODE change or step edge
module cpu_clk_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DIV_FAST   = 2,
    parameter int DIV_SLOW   = 25000000,
    parameter int MAX_CYCLES = 2048,
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       MODE,
    input  logic             STEP_BTN,
    input  logic             CLR_CNT,
`ifdef CLK_CTRL_BREAK_EN
    input  logic             BRK_VALID,
    input  logic [31:0]      BRK_PC,
    input  logic [31:0]      PC,
`endif
    output logic             CLK_EN,
    output logic [CNT_W-1:0] CYCLE_CNT,
    output logic             HALTED,
    output logic             LIMIT_HIT
);

    localparam logic [31:0]      FAST_TC = 32'(DIV_FAST - 1);
    localparam logic [31:0]      SLOW_TC = 32'(DIV_SLOW - 1);
    localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(MAX_CYCLES);

    state_e           state_q, state_d;
    mode_e            mode_q;
    logic [31:0]      div_q, div_d, div_tc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             limit_q, limit_d;
    logic             mode_chg;
    logic             step_rise;
    logic             hit_now;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_debounce (
        .clk_i  (CLK),
        .rst_i  (RST),
        .btn_i  (STEP_BTN),
        .rise_o (step_rise)
    );

`ifdef CLK_CTRL_BREAK_EN
    logic brk_match;
    assign brk_match = BRK_VALID && (PC == BRK_PC);
`endif

    assign mode_chg = (mode_e'(MODE) != mode_q);
    assign div_tc   = (mode_q == MODE_SLOW) ? SLOW_TC : FAST_TC;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_HALT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LIMIT: begin
                if (CLR_CNT) state_d = mode_to_state(MODE);
            end
`ifdef CLK_CTRL_BREAK_EN
            S_BRK: begin
                if (mode_chg || step_rise) state_d = mode_to_state(MODE);
            end
`endif
            default: state_d = mode_to_state(MODE);
        endcase
        if (hit_now) begin
            state_d = S_LIMIT;
        end
`ifdef CLK_CTRL_BREAK_EN
        else if (brk_match && (state_q == S_RUN || state_q == S_STEP)) begin
            state_d = S_BRK;
        end
`endif
    end

    // A MODE change or a clear in the same cycle swallows any due tick.
    always_comb begin
        CLK_EN = 1'b0;
        HALTED = 1'b1;
        case (state_q)
            S_RUN: begin
                HALTED = 1'b0;
                CLK_EN = (div_q == div_tc);
            end
            S_STEP: begin
                HALTED = 1'b0;
                CLK_EN = step_rise;
            end
`ifdef CLK_CTRL_BREAK_EN
            S_BRK: CLK_EN = step_rise;
`endif
            default: ;
        endcase
        if (mode_chg || CLR_CNT) CLK_EN = 1'b0;
    end

    assign hit_now = (MAX_CYCLES != 0) && CLK_EN && ((cnt_q + CNT_W'(1)) == MAX_V);

    always_comb begin
        if (state_q != S_RUN || mode_chg || div_q == div_tc) begin
            div_d = '0;
        end else begin
            div_d = div_q + 32'd1;
        end

        if (CLR_CNT) begin
            cnt_d = '0;
        end else if (CLK_EN) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (CLR_CNT) begin
            limit_d = 1'b0;
        end else begin
            limit_d = limit_q | hit_now;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q  <= MODE_HALT;
            div_q   <= '0;
            cnt_q   <= '0;
            limit_q <= 1'b0;
        end else begin
            mode_q  <= mode_e'(MODE);
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
        end
    end

    assign CYCLE_CNT = cnt_q;
    assign LIMIT_HIT = limit_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl against a cycle-level behavioural model.
module tb_cpu_clk_ctrl;

    localparam int DIV_FAST   = 2;
    localparam int DIV_SLOW   = 3;
    localparam int MAX_CYCLES = 5;
    localparam int DEB_CYCLES = 4;
    localparam int CNT_W      = 32;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [1:0]       MODE = 2'b00;
    logic             STEP_BTN = 1'b0;
    logic             CLR_CNT = 1'b0;
    logic             CLK_EN;
    logic [CNT_W-1:0] CYCLE_CNT;
    logic             HALTED;
    logic             LIMIT_HIT;
`ifdef CLK_CTRL_BREAK_EN
    logic             BRK_VALID = 1'b0;
    logic [31:0]      BRK_PC = 32'h0;
    logic [31:0]      PC = 32'h0;
`endif

    cpu_clk_ctrl #(
        .DIV_FAST   (DIV_FAST),
        .DIV_SLOW   (DIV_SLOW),
        .MAX_CYCLES (MAX_CYCLES),
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .MODE      (MODE),
        .STEP_BTN  (STEP_BTN),
        .CLR_CNT   (CLR_CNT),
`ifdef CLK_CTRL_BREAK_EN
        .BRK_VALID (BRK_VALID),
        .BRK_PC    (BRK_PC),
        .PC        (PC),
`endif
        .CLK_EN    (CLK_EN),
        .CYCLE_CNT (CYCLE_CNT),
        .HALTED    (HALTED),
        .LIMIT_HIT (LIMIT_HIT)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;
    int cyc         = 0;

    // Reference model: the mode in effect is the one sampled last cycle; ticks come
    // every DIV cycles of uninterrupted run; a button press is accepted once the
    // synced input has shown the same new value for DEB_CYCLES samples.
    logic [1:0] m_prev_mode;
    int         m_cnt;
    bit         m_hit;
    int         m_run_len;
    bit         m_rise;
    bit         m_level;
    bit         raw_q[$];
    bit         hist_q[$];

    task automatic model_reset();
        m_prev_mode = 2'b00;
        m_cnt       = 0;
        m_hit       = 1'b0;
        m_run_len   = 0;
        m_rise      = 1'b0;
        m_level     = 1'b0;
        raw_q.delete();
        raw_q.push_back(1'b0);
        raw_q.push_back(1'b0);
        hist_q.delete();
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic [1:0] mode, input logic btn, input logic clr);
        bit run_eff, step_eff, chg, exp_en, exp_halt, sync_v, all_eq;
        int div;
        MODE     = mode;
        STEP_BTN = btn;
        CLR_CNT  = clr;
        #1;
        chg      = (mode != m_prev_mode);
        run_eff  = !m_hit && (m_prev_mode == 2'b01 || m_prev_mode == 2'b10);
        step_eff = !m_hit && (m_prev_mode == 2'b11);
        div      = (m_prev_mode == 2'b10) ? DIV_SLOW : DIV_FAST;
        exp_en   = !chg && !clr &&
                   ((run_eff && (m_run_len % div == div - 1)) || (step_eff && m_rise));
        exp_halt = m_hit || (m_prev_mode == 2'b00);

        vectors += 4;
        if (CLK_EN !== exp_en) begin
            miscompares++;
            $display("FAIL clk_en cyc=%0d got=%b exp=%b", cyc, CLK_EN, exp_en);
        end
        if (CYCLE_CNT !== CNT_W'(m_cnt)) begin
            miscompares++;
            $display("FAIL cycle_cnt cyc=%0d got=%0d exp=%0d", cyc, CYCLE_CNT, m_cnt);
        end
        if (HALTED !== exp_halt) begin
            miscompares++;
            $display("FAIL halted cyc=%0d got=%b exp=%b", cyc, HALTED, exp_halt);
        end
        if (LIMIT_HIT !== m_hit) begin
            miscompares++;
            $display("FAIL limit_hit cyc=%0d got=%b exp=%b", cyc, LIMIT_HIT, m_hit);
        end
        if (CLK_EN === 1'b1) pulses++;

        if (clr) begin
            m_cnt = 0;
            m_hit = 1'b0;
        end else if (exp_en) begin
            m_cnt++;
            if (MAX_CYCLES != 0 && m_cnt == MAX_CYCLES) m_hit = 1'b1;
        end
        m_run_len   = (run_eff && !chg) ? m_run_len + 1 : 0;
        m_prev_mode = mode;

        sync_v = raw_q[0];
        hist_q.push_back(sync_v);
        if (hist_q.size() > DEB_CYCLES) void'(hist_q.pop_front());
        m_rise = 1'b0;
        if (hist_q.size() == DEB_CYCLES) begin
            all_eq = 1'b1;
            foreach (hist_q[i]) if (hist_q[i] != sync_v) all_eq = 1'b0;
            if (all_eq && sync_v != m_level) begin
                m_level = sync_v;
                m_rise  = sync_v;
            end
        end
        raw_q.push_back(btn);
        void'(raw_q.pop_front());
        cyc++;
        @(negedge CLK);
    endtask

    // Asserts RST between edges and checks the outputs respond before any clock edge.
    task automatic do_reset();
        @(negedge CLK);
        #2;
        RST      = 1'b1;
        MODE     = 2'b00;
        STEP_BTN = 1'b0;
        CLR_CNT  = 1'b0;
        #1;
        vectors += 4;
        if (CLK_EN !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_clk_en got=%b exp=0", CLK_EN);
        end
        if (CYCLE_CNT !== '0) begin
            miscompares++;
            $display("FAIL reset_cycle_cnt got=%0d exp=0", CYCLE_CNT);
        end
        if (HALTED !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_halted got=%b exp=1", HALTED);
        end
        if (LIMIT_HIT !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_limit_hit got=%b exp=0", LIMIT_HIT);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_fast_run();
        do_reset();
        pulses = 0;
        for (int i = 0; i < 7; i++) cycle(2'b01, 1'b0, 1'b0);
        #1;
        vectors += 3;
        if (pulses != 3) begin
            miscompares++;
            $display("FAIL fast_pulses got=%0d exp=3", pulses);
        end
        if (CYCLE_CNT !== 32'd3) begin
            miscompares++;
            $display("FAIL fast_cnt got=%0d exp=3", CYCLE_CNT);
        end
        if (HALTED !== 1'b0) begin
            miscompares++;
            $display("FAIL fast_halted got=%b exp=0", HALTED);
        end
        @(negedge CLK);
        cyc++;
        m_run_len++;  // the model must follow the extra cycle spent checking
        for (int i = 0; i < 12; i++) cycle(2'b10, 1'b0, 1'b0);
    endtask

    task automatic test_step_bounce();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(2'b11, 1'b0, 1'b0);
        pulses = 0;
        cycle(2'b11, 1'b1, 1'b0);
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cycle(2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(2'b11, 1'b0, 1'b0);
        #1;
        vectors += 2;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL step_pulses got=%0d exp=1", pulses);
        end
        if (CYCLE_CNT !== 32'd1) begin
            miscompares++;
            $display("FAIL step_cnt got=%0d exp=1", CYCLE_CNT);
        end
        @(negedge CLK);
        cyc++;
    endtask

    task automatic test_limit();
        do_reset();
        pulses = 0;
        for (int i = 0; i < 112; i++) cycle(2'b01, 1'b0, 1'b0);
        #1;
        vectors += 3;
        if (pulses != MAX_CYCLES) begin
            miscompares++;
            $display("FAIL limit_pulses got=%0d exp=%0d", pulses, MAX_CYCLES);
        end
        if (LIMIT_HIT !== 1'b1 || HALTED !== 1'b1) begin
            miscompares++;
            $display("FAIL limit_flags got=%b%b exp=11", LIMIT_HIT, HALTED);
        end
        if (CYCLE_CNT !== 32'(MAX_CYCLES)) begin
            miscompares++;
            $display("FAIL limit_cnt got=%0d exp=%0d", CYCLE_CNT, MAX_CYCLES);
        end
        @(negedge CLK);
        cyc++;
        cycle(2'b01, 1'b0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 10; i++) cycle(2'b01, 1'b0, 1'b0);
        vectors++;
        if (pulses != 5) begin
            miscompares++;
            $display("FAIL limit_resume_pulses got=%0d exp=5", pulses);
        end
    endtask

    task automatic test_clr_collide();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(2'b01, 1'b0, 1'b0);
        pulses = 0;
        cycle(2'b01, 1'b0, 1'b1);
        #1;
        vectors += 2;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL clr_collide_en got=%0d pulses exp=0", pulses);
        end
        if (CYCLE_CNT !== '0) begin
            miscompares++;
            $display("FAIL clr_collide_cnt got=%0d exp=0", CYCLE_CNT);
        end
        @(negedge CLK);
        cyc++;
        m_run_len++;
        for (int i = 0; i < 6; i++) cycle(2'b01, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cycle(2'b01, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(2'b01, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) cycle(2'b11, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0] rm;
        logic       rb;
        int         hold, bhold;
        rm = 2'b01; rb = 1'b0; hold = 0; bhold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                rm   = 2'($urandom_range(3, 0));
                hold = int'($urandom_range(40, 1));
            end
            if (bhold == 0) begin
                rb    = 1'($urandom_range(1, 0));
                bhold = int'($urandom_range(10, 1));
            end
            hold--;
            bhold--;
            cycle(rm, rb, ($urandom_range(24, 0) == 0));
        end
    endtask

`ifdef CLK_CTRL_BREAK_EN
    task automatic brk_cycle(input logic [1:0] mode, input logic btn);
        MODE     = mode;
        STEP_BTN = btn;
        CLR_CNT  = 1'b0;
        PC       = 32'h3000 + (CYCLE_CNT << 2);
        #1;
        if (CLK_EN === 1'b1) pulses++;
        @(negedge CLK);
    endtask

    task automatic test_break();
        do_reset();
        BRK_VALID = 1'b1;
        BRK_PC    = 32'h0000_3010;
        pulses    = 0;
        for (int i = 0; i < 20; i++) brk_cycle(2'b01, 1'b0);
        #1;
        vectors += 2;
        if (pulses != 4 || CYCLE_CNT !== 32'd4) begin
            miscompares++;
            $display("FAIL brk_stop got=%0d/%0d exp=4/4", pulses, CYCLE_CNT);
        end
        if (HALTED !== 1'b1) begin
            miscompares++;
            $display("FAIL brk_halted got=%b exp=1", HALTED);
        end
        @(negedge CLK);
        pulses = 0;
        for (int i = 0; i < 12; i++) brk_cycle(2'b01, 1'b1);
        for (int i = 0; i < 12; i++) brk_cycle(2'b01, 1'b0);
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL brk_step_pulses got=%0d exp=1", pulses);
        end
        BRK_VALID = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_fast_run();
        test_step_bounce();
        test_limit();
        test_clr_collide();
        test_async_reset();
        test_random();
`ifdef CLK_CTRL_BREAK_EN
        test_break();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
